// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller beside ID: in-flight destination scoreboard, load-use stall,
// memory-wait freeze with timeout, ID flush. Optional perf counters via `define HAZARD_PERF_EN.

module pipe_hazard_match #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_vld,
  input  logic [REG_ADDR_W-1:0] i_dest,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rt,
  output logic                  o_rs_hit,
  output logic                  o_rt_hit
);
  logic w_live;

  // $0 is hardwired, so a write to it is never a forwarding source
  assign w_live   = i_vld & (i_dest != '0);
  assign o_rs_hit = w_live & (i_dest == i_rs);
  assign o_rt_hit = w_live & (i_dest == i_rt);
endmodule

module pipe_hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int FWD_STAGES  = 3,
  parameter int MEM_TIMEOUT = 255,
  localparam int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wreg,
  input  logic                  id_is_load,
  input  logic                  mem_req,
  input  logic                  mio_ready,
  input  logic                  flush_req,
  output logic                  stall_front,
  output logic                  bubble_ex,
  output logic                  freeze_all,
  output logic                  flush_id,
  output logic [SEL_W-1:0]      fwd_rs_sel,
  output logic [SEL_W-1:0]      fwd_rt_sel,
  output logic                  mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_freeze_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_MEM_WAIT = 1'b1;

  // index 0 is EX (stage 1), index FWD_STAGES-1 is the oldest tracked stage
  logic [FWD_STAGES-1:0]                 r_vld_pipe;
  logic [FWD_STAGES-1:0][REG_ADDR_W-1:0] r_dest;
  logic                                  r_e1_load;
  logic [0:0]                            r_state;
  logic [CNT_W-1:0]                      r_cnt;
  logic                                  r_mem_err;

  logic [FWD_STAGES-1:0] w_rs_hit;
  logic [FWD_STAGES-1:0] w_rt_hit;
  logic [SEL_W-1:0]      w_rs_sel;
  logic [SEL_W-1:0]      w_rt_sel;
  logic                  w_freeze;
  logic                  w_lu_hit;
  logic                  w_stall;
  logic                  w_flush;
  logic                  w_e1_vld;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_timeout;

  generate
    for (genvar g = 0; g < FWD_STAGES; g++) begin : g_ent
      pipe_hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
        .i_vld   (r_vld_pipe[g]),
        .i_dest  (r_dest[g]),
        .i_rs    (id_rs),
        .i_rt    (id_rt),
        .o_rs_hit(w_rs_hit[g]),
        .o_rt_hit(w_rt_hit[g])
      );
    end
  endgenerate

  // scan oldest to youngest so the nearest producer overwrites
  always_comb begin
    w_rs_sel = '0;
    w_rt_sel = '0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (w_rs_hit[k]) w_rs_sel = SEL_W'(k + 1);
      if (w_rt_hit[k]) w_rt_sel = SEL_W'(k + 1);
    end
  end

  assign w_freeze = ~mio_ready & ((r_state == S_MEM_WAIT) | ((r_state == S_RUN) & mem_req));
  assign w_lu_hit = r_e1_load & ((id_use_rs & w_rs_hit[0]) | (id_use_rt & w_rt_hit[0]));
  assign w_flush  = flush_req & ~w_freeze;
  assign w_stall  = id_valid & w_lu_hit & ~flush_req & ~w_freeze;
  assign w_e1_vld = id_valid & id_wreg & ~w_flush & ~w_stall;

  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_timeout = (r_state == S_MEM_WAIT) & ~mio_ready & (w_cnt_nxt == CNT_W'(MEM_TIMEOUT));

  assign freeze_all  = w_freeze;
  assign stall_front = w_stall;
  assign bubble_ex   = w_stall;
  assign flush_id    = w_flush;
  assign fwd_rs_sel  = w_freeze ? '0 : w_rs_sel;
  assign fwd_rt_sel  = w_freeze ? '0 : w_rt_sel;
  assign mem_err     = r_mem_err;

  // only EX needs the load flag: by MEM the loaded value is forwardable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_dest     <= '0;
      r_e1_load  <= 1'b0;
    end else if (!w_freeze) begin
      r_vld_pipe <= {r_vld_pipe[FWD_STAGES-2:0], w_e1_vld};
      r_dest     <= {r_dest[FWD_STAGES-2:0], id_dest};
      r_e1_load  <= id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_timeout;
      if (r_state == S_RUN) begin
        if (mem_req && !mio_ready) begin
          r_state <= S_MEM_WAIT;
          r_cnt   <= '0;
        end
      end else begin
        if (mio_ready || w_timeout) begin
          r_state <= S_RUN;
          r_cnt   <= '0;
        end else begin
          r_cnt <= w_cnt_nxt;
        end
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_freeze_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_freeze_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_stall  && (r_stall_cnt  != '1)) r_stall_cnt  <= r_stall_cnt  + 32'd1;
      if (w_freeze && (r_freeze_cnt != '1)) r_freeze_cnt <= r_freeze_cnt + 32'd1;
      if (w_flush  && (r_flush_cnt  != '1)) r_flush_cnt  <= r_flush_cnt  + 32'd1;
    end
  end

  assign perf_stall_cnt  = r_stall_cnt;
  assign perf_freeze_cnt = r_freeze_cnt;
  assign perf_flush_cnt  = r_flush_cnt;
`endif

endmodule
